irq_request_unit: RTL and testbench
===================================

Name: irq_request_unit

Overview:
Interrupt front-end sitting directly upstream of the processor's `interrupt` input. It synchronises and edge-detects NUM_SRC external request lines, latches them as pending, and arbitrates by fixed priority. It issues one interrupt to the pipeline at a time, supplies the ISR vector, and holds off further requests until the handler's RTI completes. Stack overflow is treated as a fatal fault.

Parameters:
NUM_SRC, 4, number of external interrupt sources
SYNC_STAGES, 2, flip-flops in each input synchroniser (minimum 2)
HOLD_CYCLES, 1, cycles `interrupt` stays high per grant (1..7)
VEC_BASE, 16'h0006, address of vector slot for source 0
VEC_STRIDE, 2, address distance between consecutive vector slots

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
irq_src  in  NUM_SRC  raw asynchronous request lines; a rising edge means one request
irq_mask  in  NUM_SRC  1 = source may be granted; masked sources still latch pending
stall  in  1  HDU stall; no new grant may start while high
rti_done  in  1  one-cycle pulse when the handler's RTI retires
stack_overflow  in  1  processor StackOverFlow flag
interrupt  out  1  request to the processor's interrupt input
irq_id  out  clog2(NUM_SRC)  id of the granted source
irq_vector  out  16  ISR vector address for irq_id
in_service  out  1  high from the first interrupt cycle until RTI completes
pending  out  NUM_SRC  latched, not-yet-granted requests
overflow_err  out  1  sticky fault indicator

Behaviour:
- Reset (async assert, sync release): state IDLE; synchroniser, edge-history and pending registers = 0; all outputs = 0.
- Because edge history resets to 0, a source already high at reset release counts as exactly one edge.
- Input path: SYNC_STAGES-FF synchroniser, then a history register per source.
- Rising edge (sync=1, history=0) sets pending[i].
- With SYNC_STAGES=2, pending[i] is visible on the 3rd rising clk edge after irq_src[i] is first sampled high.
- Eligible set = pending & irq_mask. Lowest index has highest priority.
- FSM states are IDLE, ISSUE, SERVICE, FAULT.
- IDLE -> ISSUE when the eligible set is non-zero and stall=0:
  - latch irq_id = winner;
  - clear pending[winner]. If a new edge on the winner arrives in the same cycle, pending stays 1 (set wins).
- ISSUE:
  - interrupt=1 and in_service=1;
  - a counter runs HOLD_CYCLES cycles, then -> SERVICE;
  - stall during ISSUE has no effect.
- SERVICE: interrupt=0, in_service=1; -> IDLE on rti_done=1.
- The earliest next grant is the cycle after the return to IDLE, so back-to-back grants have at least 1 idle cycle between them.
- rti_done in IDLE or ISSUE is ignored.
- Pending edges keep latching in every state except FAULT.
- FAULT is entered from any state when stack_overflow=1 (highest priority transition):
  - interrupt=0, in_service=0, pending cleared and frozen, overflow_err=1;
  - exit only via reset_n.
- Vector: irq_vector = (VEC_BASE + VEC_STRIDE*irq_id) mod 2^16, registered and updated together with irq_id at grant.
- irq_id and irq_vector hold their last value outside ISSUE/SERVICE and are 0 after reset.
- Changing irq_mask affects only future arbitration; it never cancels an interrupt already in ISSUE or SERVICE.

Decomposition:
- Shared package `irq_pkg`: FSM state enum (IDLE=2'd0, ISSUE=2'd1, SERVICE=2'd2, FAULT=2'd3) and the default vector constants.
- Sub-module `irq_sync_edge`: one synchroniser plus edge detector per source, instantiated NUM_SRC times.
- Priority encoder, FSM and pending register stay in the top module.

Test Plan:
1. Reset release with irq_src=0, mask=4'hF; pulse irq_src[2] for 1 cycle -> pending=4'b0100 after 3 cycles; next cycle interrupt=1 for 1 cycle, irq_id=2, irq_vector=16'h000A, in_service stays 1 until rti_done, then goes 0.
2. Sources 1 and 3 rise in the same cycle -> id 1 granted first (vector 16'h0008); after rti_done plus 1 idle cycle, id 3 granted (vector 16'h000C).
3. Hold stall=1 for 5 cycles while pending[0]=1 -> interrupt stays 0; it asserts the cycle after stall falls.
4. irq_mask=4'b1110 with source 0 pending -> no grant; clear the mask bit -> grant id 0 next IDLE cycle. A new edge on source 0 during the grant cycle leaves pending[0]=1.
5. stack_overflow=1 during SERVICE -> next cycle overflow_err=1, in_service=0, pending=0. Further edges and rti_done are ignored until reset_n pulses low.
6. Assert reset_n=0 mid-ISSUE with HOLD_CYCLES=3 -> all outputs 0 immediately (asynchronous). A source held high at release yields exactly one grant.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt request unit.
//   irq_state_e    - FSM state encoding (IDLE, ISSUE, SERVICE, FAULT)
//   VEC_BASE_DEF   - default vector slot address for source 0
//   VEC_STRIDE_DEF - default address distance between vector slots
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2,
        FAULT   = 2'd3
    } irq_state_e;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0006;
    localparam int          VEC_STRIDE_DEF = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-source synchroniser plus rising-edge detector.
//   clk, reset_n - clock, asynchronous active-low reset
//   async_in     - raw asynchronous request line
//   rise         - one-cycle pulse on a synchronised 0->1 transition
// History resets to 0, so a line already high at reset release yields
// exactly one rise.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_request_unit.sv
// irq_request_unit: interrupt front-end for the processor.
//   clk, reset_n   - clock, asynchronous active-low reset
//   irq_src        - raw request lines, one request per rising edge
//   irq_mask       - 1 = source may be granted (masked sources still pend)
//   stall          - blocks the start of a new grant
//   rti_done       - handler return pulse, ends SERVICE
//   stack_overflow - fatal fault, forces FAULT until reset
//   interrupt      - request to the processor, HOLD_CYCLES long per grant
//   irq_id         - granted source id
//   irq_vector     - ISR vector for irq_id
//   in_service     - high from the first interrupt cycle until RTI
//   pending        - latched, not yet granted requests
//   overflow_err   - sticky fault flag
module irq_request_unit
    import irq_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYCLES = 1,
    parameter logic [15:0] VEC_BASE    = VEC_BASE_DEF,
    parameter int          VEC_STRIDE  = VEC_STRIDE_DEF,
    localparam int         ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               stall,
    input  logic               rti_done,
    input  logic               stack_overflow,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic [15:0]        irq_vector,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic               overflow_err
);

    logic [NUM_SRC-1:0] src_edge;

    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_SRC-1:0] (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (irq_src),
        .rise     (src_edge)
    );

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [15:0]        vec_q, vec_d;
    logic               int_q, int_d;
    logic               svc_q, svc_d;
    logic               err_q, err_d;

    // Fixed priority: lowest index wins, so scan downwards and let the
    // last hit overwrite.
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;

    assign eligible = pend_q & irq_mask;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        vec_d   = vec_q;
        int_d   = int_q;
        svc_d   = svc_q;
        err_d   = err_q;
        pend_d  = pend_q | src_edge;

        if (stack_overflow || state_q == FAULT) begin
            state_d = FAULT;
            pend_d  = '0;
            int_d   = 1'b0;
            svc_d   = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld && !stall) begin
                        state_d = ISSUE;
                        id_d    = win_id;
                        vec_d   = VEC_BASE + 16'(VEC_STRIDE) * 16'(win_id);
                        cnt_d   = 3'(HOLD_CYCLES - 1);
                        int_d   = 1'b1;
                        svc_d   = 1'b1;
                        // Clear the winner, but a same-cycle edge re-sets it.
                        pend_d  = (pend_q & ~(NUM_SRC'(1) << win_id)) | src_edge;
                    end
                end
                ISSUE: begin
                    if (cnt_q == 3'd0) begin
                        state_d = SERVICE;
                        int_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                SERVICE: begin
                    if (rti_done) begin
                        state_d = IDLE;
                        svc_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= 3'd0;
            id_q    <= '0;
            vec_q   <= 16'h0000;
            int_q   <= 1'b0;
            svc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            int_q   <= int_d;
            svc_q   <= svc_d;
            err_q   <= err_d;
        end
    end

    assign interrupt    = int_q;
    assign irq_id       = id_q;
    assign irq_vector   = vec_q;
    assign in_service   = svc_q;
    assign pending      = pend_q;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed bench for irq_request_unit. Two instances share stimulus:
// dut (HOLD_CYCLES=1) for the main checks, dut_h (HOLD_CYCLES=3) for the
// hold length and asynchronous reset checks.
module tb_irq_request_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] irq_src, irq_mask;
    logic       stall, rti_done, stack_overflow;

    logic       interrupt, in_service, overflow_err;
    logic [1:0] irq_id;
    logic [15:0] irq_vector;
    logic [3:0] pending;

    logic       interrupt_h, in_service_h, overflow_err_h;
    logic [1:0] irq_id_h;
    logic [15:0] irq_vector_h;
    logic [3:0] pending_h;

    irq_request_unit dut (
        .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .irq_mask(irq_mask),
        .stall(stall), .rti_done(rti_done), .stack_overflow(stack_overflow),
        .interrupt(interrupt), .irq_id(irq_id), .irq_vector(irq_vector),
        .in_service(in_service), .pending(pending), .overflow_err(overflow_err)
    );

    irq_request_unit #(.HOLD_CYCLES(3)) dut_h (
        .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .irq_mask(irq_mask),
        .stall(stall), .rti_done(rti_done), .stack_overflow(stack_overflow),
        .interrupt(interrupt_h), .irq_id(irq_id_h), .irq_vector(irq_vector_h),
        .in_service(in_service_h), .pending(pending_h), .overflow_err(overflow_err_h)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rti();
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; irq_src = 4'h0; irq_mask = 4'hF;
        stall = 1'b0; rti_done = 1'b0; stack_overflow = 1'b0;
        step(2);
        chk("rst_int",  32'(interrupt), 0);
        chk("rst_id",   32'(irq_id), 0);
        chk("rst_vec",  32'(irq_vector), 0);
        chk("rst_svc",  32'(in_service), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_err",  32'(overflow_err), 0);
        reset_n = 1'b1;
        step();

        // 1: single pulse on source 2
        irq_src = 4'h4; step();
        irq_src = 4'h0; step();
        chk("t1_pend_early", 32'(pending), 0);
        step();
        chk("t1_pend", 32'(pending), 'h4);
        chk("t1_int_pre", 32'(interrupt), 0);
        step();
        chk("t1_int",  32'(interrupt), 1);
        chk("t1_id",   32'(irq_id), 2);
        chk("t1_vec",  32'(irq_vector), 'h000A);
        chk("t1_svc",  32'(in_service), 1);
        chk("t1_pclr", 32'(pending), 0);
        step();
        chk("t1_int_off", 32'(interrupt), 0);
        step(2);
        chk("t1_svc_hold", 32'(in_service), 1);
        rti();
        chk("t1_svc_end", 32'(in_service), 0);
        chk("t1_id_hold", 32'(irq_id), 2);

        // 2: sources 1 and 3 together
        irq_src = 4'hA; step(3);
        chk("t2_pend", 32'(pending), 'hA);
        step();
        chk("t2_int1", 32'(interrupt), 1);
        chk("t2_id1",  32'(irq_id), 1);
        chk("t2_vec1", 32'(irq_vector), 'h0008);
        chk("t2_pend1", 32'(pending), 'h8);
        step();
        rti();
        chk("t2_idle", 32'(interrupt), 0);
        step();
        chk("t2_int3", 32'(interrupt), 1);
        chk("t2_id3",  32'(irq_id), 3);
        chk("t2_vec3", 32'(irq_vector), 'h000C);
        irq_src = 4'h0;
        step();
        rti();
        step(2);

        // 3: stall holds off grant for 5 cycles
        stall = 1'b1; irq_src = 4'h1; step(3);
        chk("t3_pend", 32'(pending), 'h1);
        step();
        chk("t3_int_a", 32'(interrupt), 0);
        step();
        chk("t3_int_b", 32'(interrupt), 0);
        stall = 1'b0; step();
        chk("t3_int", 32'(interrupt), 1);
        chk("t3_id",  32'(irq_id), 0);
        chk("t3_vec", 32'(irq_vector), 'h0006);
        irq_src = 4'h0;
        step();
        rti();
        step(2);

        // 4: mask blocks source 0; edge during grant keeps pending
        irq_mask = 4'hE; irq_src = 4'h1; step(3);
        chk("t4_pend", 32'(pending), 'h1);
        irq_src = 4'h0; step(3);
        chk("t4_masked", 32'(interrupt), 0);
        irq_src = 4'h1; step(2);
        chk("t4_masked2", 32'(interrupt), 0);
        irq_mask = 4'hF; step();
        chk("t4_int",  32'(interrupt), 1);
        chk("t4_id",   32'(irq_id), 0);
        chk("t4_keep", 32'(pending), 'h1);
        step();
        rti();
        step();
        chk("t4_int2",  32'(interrupt), 1);
        chk("t4_pend2", 32'(pending), 0);
        irq_src = 4'h0;
        step();
        rti();
        step(2);

        // 5: stack overflow during SERVICE
        irq_src = 4'h4; step(4);
        step();
        chk("t5_svc", 32'(in_service), 1);
        stack_overflow = 1'b1; step();
        stack_overflow = 1'b0;
        chk("t5_err",  32'(overflow_err), 1);
        chk("t5_svc0", 32'(in_service), 0);
        chk("t5_int0", 32'(interrupt), 0);
        chk("t5_pend", 32'(pending), 0);
        irq_src = 4'hC; step(4);
        rti();
        step(2);
        chk("t5_frz_pend", 32'(pending), 0);
        chk("t5_frz_int",  32'(interrupt), 0);
        chk("t5_frz_svc",  32'(in_service), 0);
        chk("t5_frz_err",  32'(overflow_err), 1);

        // 6: async reset mid-ISSUE, source high at release
        irq_src = 4'h0;
        reset_n = 1'b0; step();
        reset_n = 1'b1; step();
        chk("t6_err_clr", 32'(overflow_err_h), 0);
        irq_src = 4'h1; step(4);
        chk("t6_int_a", 32'(interrupt_h), 1);
        step();
        chk("t6_int_b", 32'(interrupt_h), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_ar_int",  32'(interrupt_h), 0);
        chk("t6_ar_svc",  32'(in_service_h), 0);
        chk("t6_ar_vec",  32'(irq_vector_h), 0);
        chk("t6_ar_pend", 32'(pending_h), 0);
        chk("t6_ar_int1", 32'(interrupt), 0);
        step();
        reset_n = 1'b1;
        step(3);
        chk("t6_pend", 32'(pending_h), 'h1);
        step();
        chk("t6_h1", 32'(interrupt_h), 1);
        chk("t6_id", 32'(irq_id_h), 0);
        step();
        chk("t6_h2", 32'(interrupt_h), 1);
        step();
        chk("t6_h3", 32'(interrupt_h), 1);
        step();
        chk("t6_h4", 32'(interrupt_h), 0);
        chk("t6_hsvc", 32'(in_service_h), 1);
        rti();
        step(5);
        chk("t6_once_int",  32'(interrupt_h), 0);
        chk("t6_once_pend", 32'(pending_h), 0);
        chk("t6_once_svc",  32'(in_service_h), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
